// File: rtl/ise_sorter.sv
// Image sort engine: classifies each image of a frame set by dominant colour,
// keeps a stably sorted table of (class, mean, id) and streams it out.
module ise_sorter #(
    parameter int unsigned NUM_IMG = 32,
    parameter int unsigned PIX_CNT = 16384,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned FRAC_W  = 3,
    localparam int unsigned IDX_W  = $clog2(NUM_IMG),
    localparam int unsigned CNT_W  = $clog2(PIX_CNT + 1),
    localparam int unsigned MEAN_W = COLOR_W + FRAC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pixel_valid,
    input  logic [IDX_W-1:0]     image_in_index,
    input  logic [3*COLOR_W-1:0] pixel_in,
    input  logic                 mode_desc,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           color_index,
    output logic [IDX_W-1:0]     image_out_index,
    output logic [MEAN_W-1:0]    mean_out,
    output logic                 done
);
    localparam int unsigned SUM_W = COLOR_W + CNT_W;
    localparam int unsigned NUM_W = SUM_W + FRAC_W;

    typedef enum logic [2:0] {S_ACC, S_FIND, S_SHIFT, S_CLEAR, S_OUT} state_t;

    typedef struct packed {
        logic [1:0]        cls;
        logic [IDX_W-1:0]  idx;
        logic [MEAN_W-1:0] mean;
    } entry_t;

    state_t             state, state_d;
    entry_t             tbl [NUM_IMG];
    logic [CNT_W-1:0]   cnt [3];
    logic [SUM_W-1:0]   sum [3];
    logic [CNT_W-1:0]   pix_cnt;
    logic [IDX_W-1:0]   cur_idx, n, p, s, k;
    logic               mode;
    logic               busy_d, out_valid_d, done_d;

    logic [COLOR_W-1:0] r_c, g_c, b_c, pix_comp_c;
    logic [1:0]         pix_cls_c;
    logic [CNT_W-1:0]   sel_cnt_c;
    logic [SUM_W-1:0]   sel_sum_c;
    entry_t             new_c, cand_c;
    logic               after_c, accept_c, last_pix_c, hs_c, last_out_c;
    logic               found_c, full_c;

    // Per-pixel class, ties resolved R over G over B
    always_comb begin
        r_c        = pixel_in[3*COLOR_W-1 -: COLOR_W];
        g_c        = pixel_in[2*COLOR_W-1 -: COLOR_W];
        b_c        = pixel_in[COLOR_W-1:0];
        pix_cls_c  = 2'd2;
        pix_comp_c = b_c;
        if (r_c >= g_c && r_c >= b_c) begin
            pix_cls_c  = 2'd0;
            pix_comp_c = r_c;
        end else if (g_c >= b_c) begin
            pix_cls_c  = 2'd1;
            pix_comp_c = g_c;
        end
    end

    // Image class by majority count and its fixed-point mean
    always_comb begin
        new_c.cls = 2'd2;
        sel_cnt_c = cnt[2];
        sel_sum_c = sum[2];
        if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) begin
            new_c.cls = 2'd0;
            sel_cnt_c = cnt[0];
            sel_sum_c = sum[0];
        end else if (cnt[1] >= cnt[2]) begin
            new_c.cls = 2'd1;
            sel_cnt_c = cnt[1];
            sel_sum_c = sum[1];
        end
        new_c.idx  = cur_idx;
        new_c.mean = MEAN_W'({sel_sum_c, {FRAC_W{1'b0}}} / NUM_W'(sel_cnt_c));
    end

    // Does the stored entry at p sort strictly after the new one
    always_comb begin
        cand_c  = tbl[p];
        after_c = 1'b0;
        if (cand_c.cls != new_c.cls)
            after_c = cand_c.cls > new_c.cls;
        else if (mode)
            after_c = cand_c.mean < new_c.mean;
        else
            after_c = cand_c.mean > new_c.mean;
    end

    assign accept_c   = pixel_valid && !busy;
    assign last_pix_c = accept_c && (pix_cnt == CNT_W'(PIX_CNT - 1));
    assign hs_c       = out_valid && out_ready;
    assign last_out_c = hs_c && (k == IDX_W'(NUM_IMG - 1));
    assign found_c    = (p == n) || after_c;
    assign full_c     = (n == IDX_W'(NUM_IMG - 1));

    always_comb begin
        state_d     = state;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state)
            S_ACC:   if (last_pix_c) state_d = S_FIND;
            S_FIND:  if (found_c) state_d = S_SHIFT;
            S_SHIFT: if (s == p) state_d = S_CLEAR;
            S_CLEAR: state_d = full_c ? S_OUT : S_ACC;
            S_OUT:   if (last_out_c) state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
        busy_d      = (state_d != S_ACC);
        out_valid_d = (state_d == S_OUT);
        done_d      = (state == S_OUT) && last_out_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_ACC;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            done      <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IMG; i++) tbl[i] <= '0;
            for (int c = 0; c < 3; c++) begin
                cnt[c] <= '0;
                sum[c] <= '0;
            end
            pix_cnt         <= '0;
            cur_idx         <= '0;
            n               <= '0;
            p               <= '0;
            s               <= '0;
            k               <= '0;
            mode            <= 1'b0;
            color_index     <= '0;
            image_out_index <= '0;
            mean_out        <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    p <= '0;
                    if (accept_c) begin
                        for (int c = 0; c < 3; c++) begin
                            if (pix_cls_c == 2'(c)) begin
                                cnt[c] <= cnt[c] + CNT_W'(1);
                                sum[c] <= sum[c] + SUM_W'(pix_comp_c);
                            end
                        end
                        pix_cnt <= pix_cnt + CNT_W'(1);
                        if (pix_cnt == '0) cur_idx <= image_in_index;
                        if (pix_cnt == '0 && n == '0) mode <= mode_desc;
                    end
                end
                S_FIND: begin
                    if (found_c) s <= n;
                    else         p <= p + IDX_W'(1);
                end
                S_SHIFT: begin
                    // Walk the hole down from n to p, then drop the new entry in
                    if (s != p) begin
                        tbl[s] <= tbl[s - IDX_W'(1)];
                        s      <= s - IDX_W'(1);
                    end else begin
                        tbl[p] <= new_c;
                    end
                end
                S_CLEAR: begin
                    for (int c = 0; c < 3; c++) begin
                        cnt[c] <= '0;
                        sum[c] <= '0;
                    end
                    pix_cnt <= '0;
                    k       <= '0;
                    if (full_c) begin
                        color_index     <= tbl[0].cls;
                        image_out_index <= tbl[0].idx;
                        mean_out        <= tbl[0].mean;
                    end else begin
                        n <= n + IDX_W'(1);
                    end
                end
                S_OUT: begin
                    if (last_out_c) begin
                        n               <= '0;
                        k               <= '0;
                        color_index     <= '0;
                        image_out_index <= '0;
                        mean_out        <= '0;
                    end else if (hs_c) begin
                        k               <= k + IDX_W'(1);
                        color_index     <= tbl[k + IDX_W'(1)].cls;
                        image_out_index <= tbl[k + IDX_W'(1)].idx;
                        mean_out        <= tbl[k + IDX_W'(1)].mean;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ise_sorter.md
# ise_sorter

Parametrised image sort engine. It accumulates a frame set of `NUM_IMG` images of `PIX_CNT` RGB pixels each, classifies every image by its dominant colour, and computes a fixed-point mean of the dominant component. It keeps a sorted table of the images and streams that table out under a valid/ready handshake. It then re-arms for the next frame set without a reset. It sits between the pixel source and the downstream classifier sink.

## Interface

- `NUM_IMG`, 32: images per frame set (≥2). Localparam `IDX_W = clog2(NUM_IMG)`.
- `PIX_CNT`, 16384: pixels per image (≥1). Localparam `CNT_W = clog2(PIX_CNT+1)`.
- `COLOR_W`, 8: bits per colour component.
- `FRAC_W`, 3: fractional bits of the mean.

Ports:

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pixel_valid` in 1: a pixel is presented this cycle.
- `image_in_index` in IDX_W: image ID; sampled with the first accepted pixel of each image.
- `pixel_in` in 3*COLOR_W: {R,G,B}, with R in the MSBs.
- `mode_desc` in 1: 0 sorts means ascending, 1 descending; sampled with the first pixel of a frame set.
- `busy` out 1: 1 means pixels are not accepted.
- `out_valid` out 1: the output entry is valid.
- `out_ready` in 1: the sink accepts the entry.
- `color_index` out 2: class of the entry, R=0, G=1, B=2.
- `image_out_index` out IDX_W: image ID of the entry.
- `mean_out` out COLOR_W+FRAC_W: mean of the entry.
- `done` out 1: one-cycle pulse after the last output handshake.

## Operation

**Reset values:** every output is 0, the table is empty, and the FSM is in ACC.

**Pixel classification:**
- R if R≥G and R≥B.
- Else G if G≥B.
- Else B.
- Per-class count is CNT_W bits. Per-class sum is COLOR_W+CNT_W bits.

**Image class:** the class with the maximum count. Ties go to R over G over B, so the chosen count is always ≥1.

**Mean:** `floor((sum << FRAC_W) / count)`, truncated to COLOR_W+FRAC_W bits. The division is combinational from the registered sums.

**Sort key:**
- Primary: class ascending.
- Secondary: mean, ascending, or descending when `mode_desc` is 1.
- Equal keys keep arrival order (stable sort).

**FSM states:**
- **ACC:** accepts a pixel when `pixel_valid && !busy`. The PIX_CNT-th accepted pixel goes to FIND.
- **FIND:** scans positions p = 0..n-1, one per cycle, where n is the number of entries already stored. It stops at the first p whose stored key sorts strictly after the new key, or at p = n.
- **SHIFT:** moves entries n-1 down to p one slot up, one per cycle. It then writes the new entry at p in 1 cycle.
- **CLEAR:** clears counts and sums in 1 cycle.
  - If n+1 < NUM_IMG, go to ACC.
  - Otherwise go to OUT.
- **OUT:** presents entry k, starting at 0. On `out_valid && out_ready`, advances to k+1. After entry NUM_IMG-1 is accepted: `done` pulses, the table is emptied, and the FSM returns to ACC.

**Boundary conditions:**
- `pixel_valid` while `busy` is high: the pixel is ignored, with no count change.
- Insert at p = n (append): no shift cycles.
- Insert at p = 0: n shift cycles.
- `reset` low at any time, including mid-FIND, mid-SHIFT, or mid-OUT: immediately empties the table and returns every output to its reset value. A partial frame set is discarded.

## Timing

- `busy` is registered. It rises the cycle after the PIX_CNT-th pixel is accepted.
- Insertion of the (n+1)-th image takes FIND (p+1) + SHIFT (n−p+1) + CLEAR (1) = n+3 cycles. `busy` falls after CLEAR unless the FSM enters OUT.
- `busy` stays 1 throughout OUT.
- The first `out_valid` comes the cycle after the final CLEAR.
- When `out_valid` is 1 and `out_ready` is 0, `color_index`, `image_out_index` and `mean_out` hold stable.
- With `out_ready` tied to 1, one entry is output per cycle.
- `done` is high for exactly the cycle after the last handshake. `out_valid` and `busy` are 0 in that same cycle.
- Pixels can be accepted from the cycle `busy` reads 0.

## Test plan

1. **Single-colour image.** Default params; image 0 is all `0xFF0000`. Expect R class, mean 2040, `busy` rising 1 cycle after pixel 16384, and insertion in 3 cycles.
2. **Class tie.** NUM_IMG=4, PIX_CNT=4. One image is 2×`0x0A0000` plus 2×`0x000014`. Expect R class, mean 80. A pixel `0x808000` counts as R.
3. **Ordering.** NUM_IMG=4, PIX_CNT=4, `mode_desc`=0. idx0 is B mean 80, idx1 R 160, idx2 R 80, idx3 G 40. Expect output (0,2,80), (0,1,160), (1,3,40), (2,0,80). With `mode_desc`=1 the first two entries swap.
4. **Stability.** Images 3 and 1 are identical and arrive in that order. Expect idx3 output before idx1.
5. **Backpressure and re-arm.** Hold `out_ready` low for 5 cycles on the second entry. Expect that entry stable for all 5 cycles, exactly 4 handshakes, `done` high for 1 cycle, then a second frame set sorted correctly.
6. **Reset mid-operation.** Assert `reset` low during SHIFT of image 3. Expect all outputs 0 and `busy` 0. A subsequent full frame set sorts with no residue from the aborted set.
